mos_bus_responder: RTL and testbench
====================================

Name: mos_bus_responder

Overview:
Memory-side responder for the tinymos6502 external bus: the block answers the CPU's ADDRESS/RW/DATA cycles. It contains a small on-chip RAM with programmable wait-state insertion, driven through RDY, plus a memory-mapped 16-bit down-counter timer that raises IRQ. It sits at the top level opposite the CPU. CPU DATA_OUT feeds this block's WDATA, and this block's RDATA feeds CPU DATA_IN.

Parameters:
RAM_DEPTH, 64, number of RAM bytes; power of two, 16..256.
RAM_BASE, 16'h0000, first address of RAM window; aligned to RAM_DEPTH.
IO_BASE, 16'hD000, first address of the 8-byte register window.
WAIT_STATES, 1, RDY-low cycles inserted per RAM access; 0..7.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous active-high reset.
ADDRESS  in  16  CPU address.
RW  in  1  1 = read, 0 = write.
SYNC  in  1  CPU opcode-fetch indicator.
WDATA  in  8  CPU write data.
RDATA  out  8  read data to CPU.
RDATA_OE  out  1  high when RDATA is valid and the bus is claimed.
RDY  out  1  0 = stall CPU in current cycle.
IRQ  out  1  active-high level interrupt request.

Behaviour:
- Decode, combinational:
  - ram_hit when ADDRESS is in [RAM_BASE, RAM_BASE+RAM_DEPTH-1].
  - io_hit when ADDRESS is in [IO_BASE, IO_BASE+7].
  - Anything else is unmapped: RDATA=8'hFF, RDATA_OE=0, RDY=1, writes ignored.
- Wait FSM, states IDLE, WAIT, DONE:
  - IDLE: on ram_hit with WAIT_STATES>0, go to WAIT with wcnt=1 and RDY=0. With WAIT_STATES=0, RDY=1 and the access completes in the same cycle.
  - WAIT: RDY=0; wcnt increments each cycle. When wcnt==WAIT_STATES, go to DONE next edge.
  - DONE: RDY=1, access completes, return to IDLE.
  - ADDRESS/RW change while in WAIT: the CPU guarantees stability, so this is not legal. The FSM does not restart.
  - io_hit never stalls.
- Completion: a cycle is complete when it is a hit and RDY=1.
  - Reads: RDATA is a combinational read of the RAM or register, RDATA_OE=1, in the completing cycle only. During WAIT, RDATA_OE=0.
  - Writes (RW=0): commit at the rising edge that ends the completing cycle. No partial writes occur while stalled.
- IO map, offsets from IO_BASE:
  - 0 RELOAD_LO (rw), 1 RELOAD_HI (rw).
  - 2 CTRL (rw): bit0 EN, bit1 IRQ_EN, bit2 AUTO. Bits 7:3 read 0.
  - 3 STATUS: bit0 PEND; read returns PEND, writing 1 to bit0 clears it.
  - 4/5 fetch counter (optional, see below). 6/7 read 8'h00, writes ignored.
- Timer:
  - Writing CTRL with EN=1 loads cnt from {RELOAD_HI,RELOAD_LO} on that edge.
  - While EN=1, cnt decrements each CLK.
  - At the edge where cnt==0: set PEND. If AUTO=1, reload cnt. If AUTO=0, clear EN and hold cnt at 0.
  - Reload value 0 with AUTO=1 sets PEND every cycle.
  - Simultaneous set and write-1-clear of PEND: set wins.
  - IRQ = PEND & IRQ_EN, registered (one cycle after PEND changes).
- Reset (any time, including mid-WAIT):
  - FSM=IDLE, wcnt=0, RDY=1, RDATA_OE=0, RDATA=8'hFF.
  - RELOAD=0, CTRL=0, PEND=0, cnt=0, IRQ=0.
  - RAM contents are undefined and not reset.

Optional Feature:
Macro MOS_RESPONDER_FETCH_CNT_EN.
- Defined: a 16-bit counter increments on every completed cycle with SYNC=1 and wraps at 16'hFFFF to 0.
  - Offset 4 reads the low byte; offset 5 reads a high byte snapshotted when offset 4 is read.
  - Any write to offset 4 clears the counter. Reset value is 0.
- Undefined: offsets 4/5 read 8'h00, writes ignored, no counter logic.

Decomposition:
- Package mos_bus_pkg holds:
  - IO offset constants (OFF_RELOAD_LO..OFF_FETCH_HI).
  - CTRL/STATUS bit-index constants.
  - Wait FSM enum typedef (IDLE, WAIT, DONE).
- One sub-module, mos_bus_timer: reload registers, CTRL, down-counter, PEND, IRQ register. The top-level block keeps decode, the wait FSM, the RAM and the read mux.

Test Plan:
- Reset: assert RST mid-WAIT with WAIT_STATES=3 -> RDY=1, RDATA_OE=0, IRQ=0 immediately; CTRL reads 8'h00 after release.
- RAM write/read, WAIT_STATES=2: write 8'hA5 to 16'h0010 -> RDY low exactly 2 cycles, commit on the completing edge; read back -> 8'hA5 with RDY low 2 cycles and RDATA_OE=1 only in the completing cycle.
- Unmapped read at 16'h8000 -> RDATA=8'hFF, RDATA_OE=0, RDY=1; a write there leaves RAM and registers unchanged.
- Timer one-shot: RELOAD=16'h0005, CTRL=8'h03 -> PEND set 6 cycles after the CTRL write edge; IRQ high one cycle later; EN reads 0; write STATUS=8'h01 -> IRQ low.
- Timer auto-reload plus clear race: RELOAD=16'h0002, CTRL=8'h07; issue the STATUS write-1 in the same cycle cnt==0 -> PEND stays 1; PEND sets every 3 cycles.
- With MOS_RESPONDER_FETCH_CNT_EN: 300 completed SYNC fetches -> offset 4 reads 8'h2C, then offset 5 reads 8'h01. Without the macro, offsets 4/5 read 8'h00.

Source files
------------

// File: rtl/mos_bus_pkg.sv
// mos_bus_pkg: shared constants and types for the tinymos6502 bus responder.
// Holds the register-window offsets, CTRL/STATUS bit indices and the
// wait-state FSM encoding used by mos_bus_responder and mos_bus_timer.
package mos_bus_pkg;

  localparam logic [2:0] OFF_RELOAD_LO = 3'd0;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd1;
  localparam logic [2:0] OFF_CTRL      = 3'd2;
  localparam logic [2:0] OFF_STATUS    = 3'd3;
  localparam logic [2:0] OFF_FETCH_LO  = 3'd4;
  localparam logic [2:0] OFF_FETCH_HI  = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_AUTO   = 2;
  localparam int STAT_PEND   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } wait_state_t;

endpackage

// File: rtl/mos_bus_timer.sv
// mos_bus_timer: memory-mapped 16-bit down-counter with interrupt.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en           completed bus write into the register window
//   wr_off/wr_data  register offset and data of that write
//   rd_off/rd_data  combinational register read (offsets 0..3, else 0)
//   irq             registered PEND & IRQ_EN
module mos_bus_timer
  import mos_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_off,
  input  logic [7:0] wr_data,
  input  logic [2:0] rd_off,
  output logic [7:0] rd_data,
  output logic       irq
);

  logic [7:0]  reload_lo;
  logic [7:0]  reload_hi;
  logic [2:0]  ctrl;
  logic [15:0] cnt;
  logic        pend;
  logic        ctrl_wr;
  logic        expire;
  logic        clr_req;

  assign ctrl_wr = wr_en && (wr_off == OFF_CTRL);
  assign expire  = ctrl[CTRL_EN] && (cnt == 16'd0);
  assign clr_req = wr_en && (wr_off == OFF_STATUS) && wr_data[STAT_PEND];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_lo <= 8'h00;
      reload_hi <= 8'h00;
      ctrl      <= 3'b000;
      cnt       <= 16'd0;
      pend      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_en && (wr_off == OFF_RELOAD_LO)) reload_lo <= wr_data;
      if (wr_en && (wr_off == OFF_RELOAD_HI)) reload_hi <= wr_data;

      // A CTRL write takes precedence over the running count.
      if (ctrl_wr) begin
        ctrl <= wr_data[2:0];
        if (wr_data[CTRL_EN]) cnt <= {reload_hi, reload_lo};
      end else if (ctrl[CTRL_EN]) begin
        if (cnt == 16'd0) begin
          if (ctrl[CTRL_AUTO]) cnt <= {reload_hi, reload_lo};
          else                 ctrl[CTRL_EN] <= 1'b0;
        end else begin
          cnt <= cnt - 16'd1;
        end
      end

      // Expiry beats a simultaneous write-1-to-clear so no event is lost.
      if (expire)       pend <= 1'b1;
      else if (clr_req) pend <= 1'b0;

      irq <= pend & ctrl[CTRL_IRQ_EN];
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (rd_off)
      OFF_RELOAD_LO: rd_data = reload_lo;
      OFF_RELOAD_HI: rd_data = reload_hi;
      OFF_CTRL:      rd_data = {5'b00000, ctrl};
      OFF_STATUS:    rd_data = {7'b0000000, pend};
      default:       rd_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/mos_bus_responder.sv
// mos_bus_responder: memory-side responder for the tinymos6502 bus.
// On-chip RAM with wait-state insertion via RDY, plus an 8-byte register
// window holding the timer and an optional opcode-fetch counter.
// Optional feature macro: MOS_RESPONDER_FETCH_CNT_EN (fetch counter at
// offsets 4/5; when undefined those offsets read 0 and ignore writes).
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   ADDRESS/RW      CPU address, 1 = read / 0 = write
//   SYNC            CPU opcode-fetch indicator
//   WDATA           CPU write data
//   RDATA/RDATA_OE  read data and its valid/bus-claim flag
//   RDY             0 stalls the CPU in the current cycle
//   IRQ             level interrupt request
module mos_bus_responder
  import mos_bus_pkg::*;
#(
  parameter int          RAM_DEPTH   = 64,
  parameter logic [15:0] RAM_BASE    = 16'h0000,
  parameter logic [15:0] IO_BASE     = 16'hD000,
  parameter int          WAIT_STATES = 1
)(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ADDRESS,
  input  logic        RW,
  input  logic        SYNC,
  input  logic [7:0]  WDATA,
  output logic [7:0]  RDATA,
  output logic        RDATA_OE,
  output logic        RDY,
  output logic        IRQ
);

  localparam int          AW  = $clog2(RAM_DEPTH);
  localparam logic [3:0]  WS4 = 4'(WAIT_STATES);

  logic          ram_hit;
  logic          io_hit;
  logic [15:0]   io_rel;
  logic [2:0]    io_off;
  logic          stall;
  logic          complete;
  logic          ram_we;
  logic          io_we;
  logic          rd_oe;
  logic [7:0]    ram_q;
  logic [7:0]    io_q;
  logic [7:0]    tmr_rdata;
  logic [AW-1:0] ram_idx;
  logic [7:0]    mem [RAM_DEPTH];
  wait_state_t   state;
  logic [2:0]    wcnt;
  logic          unused_bits;

  assign ram_hit = (ADDRESS[15:AW] == RAM_BASE[15:AW]);
  assign io_hit  = ({1'b0, ADDRESS} >= {1'b0, IO_BASE}) &&
                   ({1'b0, ADDRESS} <= ({1'b0, IO_BASE} + 17'd7));
  assign io_rel  = ADDRESS - IO_BASE;
  assign io_off  = io_rel[2:0];
  assign ram_idx = ADDRESS[AW-1:0];
  assign unused_bits = ^{SYNC, io_rel[15:3]};

  // The first RAM cycle (seen in IDLE) is itself a stall cycle, so the CPU
  // sees exactly WAIT_STATES low cycles: IDLE plus WAIT with wcnt=1..WS-1.
  always_comb begin
    stall = 1'b0;
    if (WAIT_STATES > 0) begin
      case (state)
        IDLE:    stall = ram_hit;
        WAIT:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      wcnt  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ram_hit && (WAIT_STATES > 0)) begin
            wcnt  <= 3'd1;
            state <= (WS4 == 4'd1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          wcnt <= wcnt + 3'd1;
          if (({1'b0, wcnt} + 4'd1) == WS4) state <= DONE;
        end
        DONE: begin
          wcnt  <= 3'd0;
          state <= IDLE;
        end
        default: begin
          wcnt  <= 3'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Reset overrides the combinational bus outputs so a mid-WAIT reset
  // releases the CPU immediately even while the address stays on RAM.
  assign complete = (ram_hit || io_hit) && !stall && !RST;
  assign ram_we   = complete && ram_hit && !RW;
  assign io_we    = complete && io_hit && !RW;
  assign rd_oe    = complete && RW;

  assign RDY      = RST || !stall;
  assign RDATA_OE = rd_oe;
  assign RDATA    = !rd_oe ? 8'hFF : (ram_hit ? ram_q : io_q);

  always_ff @(posedge CLK) begin
    if (ram_we) mem[ram_idx] <= WDATA;
  end
  assign ram_q = mem[ram_idx];

  mos_bus_timer u_timer (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (io_we),
    .wr_off  (io_off),
    .wr_data (WDATA),
    .rd_off  (io_off),
    .rd_data (tmr_rdata),
    .irq     (IRQ)
  );

`ifdef MOS_RESPONDER_FETCH_CNT_EN
  logic [15:0] fetch_cnt;
  logic [7:0]  fetch_hi;

  // Reading the low byte freezes the high byte so a two-byte read is coherent.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_cnt <= 16'd0;
      fetch_hi  <= 8'h00;
    end else begin
      if (io_we && (io_off == OFF_FETCH_LO)) fetch_cnt <= 16'd0;
      else if (complete && SYNC)             fetch_cnt <= fetch_cnt + 16'd1;
      if (rd_oe && io_hit && (io_off == OFF_FETCH_LO)) fetch_hi <= fetch_cnt[15:8];
    end
  end
`endif

  always_comb begin
    io_q = 8'h00;
    case (io_off)
      OFF_RELOAD_LO, OFF_RELOAD_HI, OFF_CTRL, OFF_STATUS: io_q = tmr_rdata;
`ifdef MOS_RESPONDER_FETCH_CNT_EN
      OFF_FETCH_LO: io_q = fetch_cnt[7:0];
      OFF_FETCH_HI: io_q = fetch_hi;
`endif
      default: io_q = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mos_bus_responder.sv
// tb_mos_bus_responder: self-checking bench for mos_bus_responder with
// WAIT_STATES=2. RAM contents are tracked in a byte array, timer PEND/IRQ
// are predicted from the set-edge arithmetic k*(RELOAD+1).
module tb_mos_bus_responder;

  localparam int          WS = 2;
  localparam logic [15:0] IO = 16'hD000;

  logic        CLK;
  logic        RST;
  logic [15:0] ADDRESS;
  logic        RW;
  logic        SYNC;
  logic [7:0]  WDATA;
  logic [7:0]  RDATA;
  logic        RDATA_OE;
  logic        RDY;
  logic        IRQ;

  int total;
  int bad;

  logic [7:0] mem_model [64];
  int         written [$];

  logic [7:0] r;
  logic       oe;
  logic       iq;
  int         st;
  int         eo;

  mos_bus_responder #(
    .RAM_DEPTH   (64),
    .RAM_BASE    (16'h0000),
    .IO_BASE     (IO),
    .WAIT_STATES (WS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ADDRESS  (ADDRESS),
    .RW       (RW),
    .SYNC     (SYNC),
    .WDATA    (WDATA),
    .RDATA    (RDATA),
    .RDATA_OE (RDATA_OE),
    .RDY      (RDY),
    .IRQ      (IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction; returns at #1 after the edge that completes it.
  task automatic bus(input logic [15:0] a, input logic rw, input logic [7:0] wd, input logic sy,
                     output logic [7:0] rd, output logic rd_oe, output int stalls,
                     output int early_oe, output logic irq_s);
    ADDRESS = a; RW = rw; WDATA = wd; SYNC = sy;
    stalls = 0; early_oe = 0; rd = 8'hxx; rd_oe = 1'bx; irq_s = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (RDY === 1'b1) begin
        rd = RDATA; rd_oe = RDATA_OE; irq_s = IRQ;
        @(posedge CLK); #1;
        return;
      end
      stalls++;
      if (RDATA_OE !== 1'b0) early_oe++;
      @(posedge CLK); #1;
    end
    total++; bad++;
    $error("FAIL bus_timeout: observed=%0d stalls expected=completion", stalls);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus(a, 1'b0, d, 1'b0, r, oe, st, eo, iq);
  endtask

  task automatic io_rd_chk(input string tag, input logic [2:0] off, input logic [7:0] exp);
    bus(IO + {13'd0, off}, 1'b1, 8'h00, 1'b0, r, oe, st, eo, iq);
    check(tag, r, exp);
    check({tag, "_oe"}, oe, 1'b1);
  endtask

  task automatic ram_wr_chk(input string tag, input logic [5:0] idx, input logic [7:0] d);
    bus({10'd0, idx}, 1'b0, d, 1'b0, r, oe, st, eo, iq);
    mem_model[idx] = d;
    written.push_back(int'(idx));
    check({tag, "_stalls"}, st, WS);
    check({tag, "_oe"}, oe, 1'b0);
  endtask

  task automatic ram_rd_chk(input string tag, input logic [5:0] idx);
    bus({10'd0, idx}, 1'b1, 8'h00, 1'b0, r, oe, st, eo, iq);
    check(tag, r, mem_model[idx]);
    check({tag, "_oe"}, oe, 1'b1);
    check({tag, "_stalls"}, st, WS);
    check({tag, "_early_oe"}, eo, 0);
  endtask

  // Programs RELOAD and CTRL, then each cycle either reads STATUS or issues
  // a write-1-clear; PEND is expected to set on edges k*(rl+1) after the
  // CTRL write (only k=1 without AUTO), IRQ to follow PEND by one cycle.
  task automatic timer_run(input string tag, input logic [15:0] rl, input logic [7:0] ctl,
                           input int clr_a, input int clr_b, input int ncyc);
    logic p_prev, p_cur, set, clr;
    int   e;
    wr(IO + 16'd0, rl[7:0]);
    wr(IO + 16'd1, rl[15:8]);
    wr(IO + 16'd2, ctl);
    p_prev = 1'b0; p_cur = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      clr = (c == clr_a) || (c == clr_b);
      if (clr) begin
        bus(IO + 16'd3, 1'b0, 8'h01, 1'b0, r, oe, st, eo, iq);
      end else begin
        bus(IO + 16'd3, 1'b1, 8'h00, 1'b0, r, oe, st, eo, iq);
        check($sformatf("%s_pend_c%0d", tag, c), r, {7'd0, p_cur});
      end
      check($sformatf("%s_irq_c%0d", tag, c), iq, p_prev & ctl[1]);
      e = c + 1;
      set = ((e % (int'(rl) + 1)) == 0) && (ctl[2] || (e == int'(rl) + 1));
      p_prev = p_cur;
      p_cur  = set | (p_cur & ~clr);
    end
  endtask

  initial begin
    logic [7:0] d;
    int         idx;
    total = 0; bad = 0;
    ADDRESS = 16'h0010; RW = 1'b1; SYNC = 1'b0; WDATA = 8'h00;
    RST = 1'b1;

    // Reset state with the address sitting on RAM
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_rdy", RDY, 1'b1);
    check("rst_oe", RDATA_OE, 1'b0);
    check("rst_rdata", RDATA, 8'hFF);
    check("rst_irq", IRQ, 1'b0);
    @(posedge CLK); #1;
    ADDRESS = 16'h8000;
    RST = 1'b0;
    io_rd_chk("rst_ctrl", 3'd2, 8'h00);
    io_rd_chk("rst_status", 3'd3, 8'h00);
    io_rd_chk("rst_reload_lo", 3'd0, 8'h00);

    // RAM write/read with wait states
    ram_wr_chk("ram_wr_10", 6'h10, 8'hA5);
    ram_rd_chk("ram_rd_10", 6'h10);
    ram_wr_chk("ram_wr_3f", 6'h3F, 8'h3C);
    ram_rd_chk("ram_rd_3f", 6'h3F);

    // Unmapped accesses
    bus(16'h8000, 1'b1, 8'h00, 1'b0, r, oe, st, eo, iq);
    check("unm_rdata", r, 8'hFF);
    check("unm_oe", oe, 1'b0);
    check("unm_stalls", st, 0);
    bus(16'h0040, 1'b1, 8'h00, 1'b0, r, oe, st, eo, iq);
    check("unm_40_oe", oe, 1'b0);
    check("unm_40_stalls", st, 0);
    wr(16'h8010, 8'h5A);
    wr(16'hD008, 8'h77);
    wr(16'hCFFF, 8'h66);
    ram_rd_chk("unm_ram_keep", 6'h10);
    io_rd_chk("unm_reload_keep", 3'd0, 8'h00);
    io_rd_chk("io_off7", 3'd7, 8'h00);
    wr(IO + 16'd6, 8'hEE);
    io_rd_chk("io_off6", 3'd6, 8'h00);

    // Randomised RAM traffic against the byte-array model
    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 63);
      d   = 8'($urandom);
      ram_wr_chk($sformatf("rnd_wr%0d", i), idx[5:0], d);
      idx = written[$urandom_range(0, written.size() - 1)];
      ram_rd_chk($sformatf("rnd_rd%0d", i), idx[5:0]);
    end

    // Randomised register readback with the timer disabled
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      wr(IO + 16'd0, d);
      io_rd_chk($sformatf("rnd_rl_lo%0d", i), 3'd0, d);
      d = 8'($urandom);
      wr(IO + 16'd1, d);
      io_rd_chk($sformatf("rnd_rl_hi%0d", i), 3'd1, d);
      d = 8'($urandom) & 8'hFE;
      wr(IO + 16'd2, d);
      io_rd_chk($sformatf("rnd_ctrl%0d", i), 3'd2, d & 8'h06);
    end
    wr(IO + 16'd2, 8'h00);

    // One-shot timer, then clear PEND
    timer_run("oneshot", 16'h0005, 8'h03, 9, -1, 13);
    io_rd_chk("oneshot_ctrl", 3'd2, 8'h02);
    wr(IO + 16'd2, 8'h00);

    // Auto-reload with write-1-clear racing a set (cycle 5 -> edge 6)
    timer_run("auto", 16'h0002, 8'h07, 5, 7, 14);
    io_rd_chk("auto_ctrl", 3'd2, 8'h07);

    // Reset in the middle of a RAM wait
    check("pre_rst_irq", IRQ, 1'b1);
    ADDRESS = 16'h0010; RW = 1'b1; SYNC = 1'b0;
    @(negedge CLK);
    check("midw_idle_rdy", RDY, 1'b0);
    @(posedge CLK); #2;
    check("midw_wait_rdy", RDY, 1'b0);
    RST = 1'b1;
    #1;
    check("midw_rst_rdy", RDY, 1'b1);
    check("midw_rst_oe", RDATA_OE, 1'b0);
    check("midw_rst_irq", IRQ, 1'b0);
    check("midw_rst_rdata", RDATA, 8'hFF);
    repeat (2) @(posedge CLK);
    #1;
    ADDRESS = 16'h8000;
    RST = 1'b0;
    io_rd_chk("post_rst_ctrl", 3'd2, 8'h00);
    io_rd_chk("post_rst_status", 3'd3, 8'h00);
    io_rd_chk("post_rst_reload_hi", 3'd1, 8'h00);
    ram_rd_chk("post_rst_ram", 6'h10);

    // Opcode-fetch counter
    for (int i = 0; i < 3; i++) bus(16'h0000, 1'b1, 8'h00, 1'b1, r, oe, st, eo, iq);
    wr(IO + 16'd4, 8'h00);
    for (int i = 0; i < 300; i++) begin
      bus(16'(i % 64), 1'b1, 8'h00, 1'b1, r, oe, st, eo, iq);
      if (i % 60 == 0) bus(16'h8000, 1'b1, 8'h00, 1'b1, r, oe, st, eo, iq);
    end
`ifdef MOS_RESPONDER_FETCH_CNT_EN
    io_rd_chk("fetch_lo", 3'd4, 8'h2C);
    io_rd_chk("fetch_hi", 3'd5, 8'h01);
`else
    io_rd_chk("fetch_lo", 3'd4, 8'h00);
    io_rd_chk("fetch_hi", 3'd5, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
